// File: rtl/ipu_int_ctrl.sv
// rtl/ipu_int_ctrl.sv - IPU detection stability filter, coordinate queue and processor interrupt handshake
//
// Purpose:
//   Filters per-frame cell detections for stability, queues accepted grid
//   coordinates and delivers each one to the processor as a level interrupt
//   (ipu_int) with the coordinate held on grid_coord until int_ack is seen.
//
// Ports:
//   clk         in   1        system clock, rising edge
//   rst         in   1        asynchronous active-high reset
//   det_valid   in   1        one-cycle pulse per processed frame
//   det_coord   in   4        detected cell (legal 0-8), sampled with det_valid
//   int_ack     in   1        processor acknowledge, level
//   ipu_int     out  1        interrupt request, registered
//   grid_coord  out  4        coordinate of the current interrupt, registered
//   pending     out  AW+1     queued entries, excluding the one being delivered
//   overflow    out  1        sticky: an accepted coordinate was dropped

module ipu_int_ctrl #(
  parameter int STABLE_FRAMES = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          det_valid,
  input  logic [3:0]                    det_coord,
  input  logic                          int_ack,
  output logic                          ipu_int,
  output logic [3:0]                    grid_coord,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    STABLE_L = 4'(STABLE_FRAMES);
  localparam logic [CW-1:0] DEPTH_L  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Stability filter state
  logic [3:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
  logic [3:0] run_q, run_d;
  logic       armed_q, armed_d;
  logic       push;

  // Queue state
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty, fifo_full;
  logic          pop, push_acc;
  logic          overflow_q, overflow_d;

  // Handshake state
  state_t     state_q, state_d;
  logic       ipu_int_q, ipu_int_d;
  logic [3:0] grid_q, grid_d;

  // ---------------------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------------------
  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    run_d      = run_q;
    armed_d    = armed_q;
    push       = 1'b0;
    if (det_valid) begin
      if (det_coord > 4'd8) begin
        // Illegal detection breaks any run in progress.
        last_d     = 4'd0;
        last_vld_d = 1'b0;
        run_d      = 4'd0;
        armed_d    = 1'b1;
      end else begin
        if (last_vld_q && (det_coord == last_q)) begin
          if (run_q < STABLE_L) begin
            run_d = run_q + 4'd1;
          end
        end else begin
          last_d     = det_coord;
          last_vld_d = 1'b1;
          run_d      = 4'd1;
          armed_d    = 1'b1;
        end
        // Uses the post-update run/armed values so STABLE_FRAMES=1 pushes
        // on the very first detection of a new coordinate.
        if (armed_d && (run_d == STABLE_L)) begin
          push    = 1'b1;
          armed_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= 4'd0;
      last_vld_q <= 1'b0;
      run_q      <= 4'd0;
      armed_q    <= 1'b1;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      run_q      <= run_d;
      armed_q    <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Coordinate queue
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_L);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A simultaneous pop frees a slot, so a push into a full queue still lands.
  assign push_acc   = push && (!fifo_full || pop);

  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_acc) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && !push_acc) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_q] <= det_coord;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ipu_int_d = ipu_int_q;
    grid_d    = grid_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          grid_d    = mem[rd_q];
          ipu_int_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          ipu_int_d = 1'b0;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!int_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        ipu_int_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ipu_int_q <= 1'b0;
      grid_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      ipu_int_q <= ipu_int_d;
      grid_q    <= grid_d;
    end
  end

  assign ipu_int    = ipu_int_q;
  assign grid_coord = grid_q;
  assign pending    = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ipu_int_ctrl.sv
// tb/tb_ipu_int_ctrl.sv - directed table-driven bench for ipu_int_ctrl
module tb_ipu_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       det_valid;
  logic [3:0] det_coord;
  logic       int_ack;
  logic       ipu_int;
  logic [3:0] grid_coord;
  logic [2:0] pending;
  logic       overflow;

  logic       det_valid1;
  logic [3:0] det_coord1;
  logic       int_ack1;
  logic       ipu_int1;
  logic [3:0] grid_coord1;
  logic [1:0] pending1;
  logic       overflow1;

  always #5 clk = ~clk;

  ipu_int_ctrl #(.STABLE_FRAMES(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .det_valid(det_valid), .det_coord(det_coord),
    .int_ack(int_ack), .ipu_int(ipu_int), .grid_coord(grid_coord),
    .pending(pending), .overflow(overflow)
  );

  ipu_int_ctrl #(.STABLE_FRAMES(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .det_valid(det_valid1), .det_coord(det_coord1),
    .int_ack(int_ack1), .ipu_int(ipu_int1), .grid_coord(grid_coord1),
    .pending(pending1), .overflow(overflow1)
  );

  typedef struct {
    logic       dv;
    logic [3:0] c;
    logic       ack;
    logic       e_int;
    logic [3:0] e_grid;
    logic [2:0] e_pend;
    logic       e_ov;
  } vec_t;

  vec_t vec [256];
  int   n_vec = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic dv, input logic [3:0] c, input logic ack,
                     input logic ei, input logic [3:0] eg, input logic [2:0] ep, input logic eo);
    vec[n_vec].dv     = dv;
    vec[n_vec].c      = c;
    vec[n_vec].ack    = ack;
    vec[n_vec].e_int  = ei;
    vec[n_vec].e_grid = eg;
    vec[n_vec].e_pend = ep;
    vec[n_vec].e_ov   = eo;
    n_vec++;
  endtask

  task automatic check_main(input string tag, input int idx, input logic ei, input logic [3:0] eg,
                            input logic [2:0] ep, input logic eo);
    chk({tag, "_int"},  idx, 32'(ipu_int),    32'(ei));
    chk({tag, "_grid"}, idx, 32'(grid_coord), 32'(eg));
    chk({tag, "_pend"}, idx, 32'(pending),    32'(ep));
    chk({tag, "_ovf"},  idx, 32'(overflow),   32'(eo));
  endtask

  task automatic check_one(input string tag, input int idx, input logic ei, input logic [3:0] eg,
                           input logic [1:0] ep, input logic eo);
    chk({tag, "_int"},  idx, 32'(ipu_int1),    32'(ei));
    chk({tag, "_grid"}, idx, 32'(grid_coord1), 32'(eg));
    chk({tag, "_pend"}, idx, 32'(pending1),    32'(ep));
    chk({tag, "_ovf"},  idx, 32'(overflow1),   32'(eo));
  endtask

  task automatic step(input logic dv, input logic [3:0] c, input logic ack);
    det_valid = dv;
    det_coord = c;
    int_ack   = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic dv, input logic [3:0] c);
    det_valid1 = dv;
    det_coord1 = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] five [5];
    logic [2:0] p;
    five[0] = 4'd0; five[1] = 4'd1; five[2] = 4'd5; five[3] = 4'd6; five[4] = 4'd8;

    // Three stable frames of 2 -> push, then interrupt one edge later.
    add(1, 2, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 2, 0, 0);
    // Five more identical frames: saturated, disarmed, no extra push.
    for (int i = 0; i < 5; i++) add(1, 2, 0, 1, 2, 0, 0);
    // Ack pulse, back to IDLE with empty queue.
    add(0, 0, 1, 0, 2, 0, 0);
    add(0, 0, 0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 2, 0, 0);
    // 4,4,9,4,4,4 -> single push of 4 after the last frame.
    add(1, 4, 0, 0, 2, 0, 0);
    add(1, 4, 0, 0, 2, 0, 0);
    add(1, 9, 0, 0, 2, 0, 0);
    add(1, 4, 0, 0, 2, 0, 0);
    add(1, 4, 0, 0, 2, 0, 0);
    add(1, 4, 0, 0, 2, 1, 0);
    add(0, 0, 0, 1, 4, 0, 0);
    add(0, 0, 1, 0, 4, 0, 0);
    add(0, 0, 0, 0, 4, 0, 0);
    // 7,7,3,3,3 -> single push of 3.
    add(1, 7, 0, 0, 4, 0, 0);
    add(1, 7, 0, 0, 4, 0, 0);
    add(1, 3, 0, 0, 4, 0, 0);
    add(1, 3, 0, 0, 4, 0, 0);
    add(1, 3, 0, 0, 4, 1, 0);
    add(0, 0, 0, 1, 3, 0, 0);
    // While in REQ: five distinct stable coordinates, fifth dropped.
    p = 3'd0;
    for (int k = 0; k < 5; k++) begin
      add(1, five[k], 0, 1, 3, p, 0);
      add(1, five[k], 0, 1, 3, p, 0);
      if (k < 4) p = p + 3'd1;
      add(1, five[k], 0, 1, 3, p, (k == 4));
    end
    // Deliver the four queued values in order with two low cycles between.
    for (int k = 0; k < 4; k++) begin
      add(0, 0, 1, 0, (k == 0) ? 4'd3 : five[k-1], p, 1);
      add(0, 0, 0, 0, (k == 0) ? 4'd3 : five[k-1], p, 1);
      p = p - 3'd1;
      add(0, 0, 0, 1, five[k], p, 1);
    end
    // Ack held 10 cycles: stays in RELEASE while a new coordinate queues.
    add(0, 0, 1, 0, 6, 0, 1);
    add(1, 7, 1, 0, 6, 0, 1);
    add(1, 7, 1, 0, 6, 0, 1);
    add(1, 7, 1, 0, 6, 1, 1);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 6, 1, 1);
    add(0, 0, 0, 0, 6, 1, 1);
    add(0, 0, 0, 1, 7, 0, 1);
    // Build up pending=2 under an active interrupt.
    add(1, 2, 0, 1, 7, 0, 1);
    add(1, 2, 0, 1, 7, 0, 1);
    add(1, 2, 0, 1, 7, 1, 1);
    add(1, 4, 0, 1, 7, 1, 1);
    add(1, 4, 0, 1, 7, 1, 1);
    add(1, 4, 0, 1, 7, 2, 1);

    rst        = 1'b1;
    det_valid  = 1'b0;
    det_coord  = 4'd0;
    int_ack    = 1'b0;
    det_valid1 = 1'b0;
    det_coord1 = 4'd0;
    int_ack1   = 1'b0;
    #12;
    check_main("reset", 0, 0, 0, 0, 0);
    check_one("reset1", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      step(vec[i].dv, vec[i].c, vec[i].ack);
      check_main("vec", i, vec[i].e_int, vec[i].e_grid, vec[i].e_pend, vec[i].e_ov);
    end

    // Asynchronous reset mid-handshake with entries queued.
    det_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_main("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 6, 0); check_main("post_rst", 0, 0, 0, 0, 0);
    step(1, 6, 0); check_main("post_rst", 1, 0, 0, 0, 0);
    step(1, 6, 0); check_main("post_rst", 2, 0, 0, 1, 0);
    step(0, 0, 0); check_main("post_rst", 3, 1, 6, 0, 0);

    // STABLE_FRAMES=1 instance: immediate push, re-arm only on a change.
    step1(1, 5); check_one("sf1", 0, 0, 0, 1, 0);
    step1(1, 5); check_one("sf1", 1, 1, 5, 0, 0);
    step1(1, 9); check_one("sf1", 2, 1, 5, 0, 0);
    step1(1, 5); check_one("sf1", 3, 1, 5, 1, 0);
    step1(0, 0); check_one("sf1", 4, 1, 5, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ipu_int_ctrl.md
# ipu_int_ctrl

Interrupt-requesting side of the IPU-to-processor handshake. It takes per-frame cell detections from the image pipeline and filters them for stability. Accepted grid coordinates are queued, and each one is delivered to `proc` by raising `ipu_int` with the value held on `grid_coord` until the processor returns `int_ack`. It sits between the IPU detection logic and the processor's `ipu_int`/`int_ack`/`grid_coord` ports. It replaces the free-running `grid_coord` register as the source of the coordinate.

## Interface

Parameters:
- `STABLE_FRAMES`, default 3: consecutive identical valid detections required before a coordinate is accepted. Range 1-15.
- `FIFO_DEPTH`, default 4: number of accepted coordinates queued awaiting delivery. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `det_valid`  in  1  one-cycle pulse, one per processed frame.
- `det_coord`  in  4  detected cell, sampled when `det_valid`=1. Legal values are 0-8.
- `int_ack`  in  1  processor acknowledge, level.
- `ipu_int`  out  1  interrupt request, level, registered.
- `grid_coord`  out  4  coordinate for the current interrupt, registered.
- `pending`  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries, not counting the one being delivered.
- `overflow`  out  1  sticky. Set when an accepted coordinate is dropped because the FIFO is full.

## Operation

Stability filter:
- A `det_valid` with `det_coord` > 8 is discarded. It clears the run counter and the last-coordinate register, and re-arms the filter.
- A `det_valid` with a legal coordinate equal to the last coordinate increments the run counter. The counter saturates at `STABLE_FRAMES`.
- A `det_valid` with a legal coordinate different from the last coordinate loads the last-coordinate register, sets the run counter to 1, and re-arms the filter.
- When the run counter reaches `STABLE_FRAMES` while armed, the coordinate is pushed once and the filter disarms.
- Further identical detections never push again until the filter is re-armed.
- With `STABLE_FRAMES`=1, every new legal coordinate pushes on its first detection.

FIFO:
- Synchronous, `FIFO_DEPTH` entries, with wrap-around pointers.
- A push when full is dropped and sets `overflow`. The filter still disarms.
- A push and a pop in the same cycle are both performed. When full, this push is accepted, not dropped.
- `pending` reflects the count after each edge.

Handshake FSM:
- IDLE: if the FIFO is not empty, pop the head into `grid_coord`, set `ipu_int`=1, and go to REQ. `int_ack` is ignored in IDLE.
- REQ: hold `ipu_int`=1 and a stable `grid_coord`. When `int_ack`=1 is sampled, clear `ipu_int` and go to RELEASE.
- RELEASE: hold `ipu_int`=0 and keep `grid_coord` unchanged. When `int_ack`=0 is sampled, go to IDLE.
- `grid_coord` changes only on the IDLE-to-REQ transition.

## Timing

- Reset values: `ipu_int`=0, `grid_coord`=0, `pending`=0, `overflow`=0. FIFO empty, FSM in IDLE, run counter 0, filter armed, last-coordinate register invalid.
- Reset asserted mid-handshake or mid-run aborts immediately. Queued entries are lost.
- Push latency: the entry is in the FIFO after the edge that samples the qualifying `det_valid` (edge E).
- Interrupt latency: if the FSM is in IDLE, `ipu_int` and `grid_coord` update at edge E+1.
- Deassert latency: `ipu_int` falls on the first edge that samples `int_ack`=1 in REQ.
- Back-to-back interrupts: the earliest next `ipu_int` rise is one edge after `int_ack`=0 is sampled in RELEASE. So `ipu_int` is low for at least 2 cycles between requests.
- An `int_ack` held high forever leaves the FSM in RELEASE. Detections continue to queue.

## Test plan

- Reset, then `det_coord`=2 with `det_valid` on 3 frames (`STABLE_FRAMES`=3) -> `ipu_int`=1 and `grid_coord`=2 one edge after the third sample, `pending`=0.
- Same as above, then 5 more frames of coordinate 2 with no `int_ack` -> no extra push, `pending` stays 0, `ipu_int` stays 1.
- Frames 4,4,9,4,4,4 -> the 9 resets the run, so a single push of 4 occurs after the last frame. Frames 7,7,3,3,3 -> a single push of 3.
- While in REQ, push 5 distinct stable coordinates with `FIFO_DEPTH`=4 -> `pending`=4, `overflow`=1, the 5th is dropped. Acks then deliver the 4 queued values in order, each with ≥2 low cycles of `ipu_int` between them.
- Raise `int_ack` for 1 cycle in REQ -> `ipu_int` falls at that edge and rises again 2 edges later if `pending`>0. Hold `int_ack` high 10 cycles -> no new interrupt until it drops.
- Assert `rst` while `ipu_int`=1 with `pending`=2 -> all outputs return to reset values immediately. Release reset, then a new stable coordinate 6 -> normal delivery of 6.
